// File: rtl/axis_bram_line_bridge_pkg.sv
// Shared types and helpers for the AXI-Stream <-> wide-BRAM line bridge.
package axis_bram_line_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrFill,
        StWrCommit,
        StRdIssue,
        StRdWait,
        StRdDrain,
        StFinish
    } state_e;

    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ  = 1'b1;

    // Width of a word pointer within a line; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned wpl);
        return (wpl > 1) ? $clog2(wpl) : 1;
    endfunction

endpackage

// File: rtl/axis_bram_line_buf.sv
// Line buffer: WPL words of DW bits. Supports a single-word write (optionally
// zeroing every word above it), a full-line load, and a word read mux.
module axis_bram_line_buf
    import axis_bram_line_bridge_pkg::*;
#(
    parameter int unsigned DW  = 32,
    parameter int unsigned WPL = 36,
    parameter int unsigned PW  = ptr_width(WPL)
) (
    input  logic              clk_i,
    input  logic              word_we_i,
    input  logic [PW-1:0]     word_idx_i,
    input  logic [DW-1:0]     word_data_i,
    input  logic              zero_above_i,
    input  logic              line_we_i,
    input  logic [DW*WPL-1:0] line_data_i,
    input  logic [PW-1:0]     rd_idx_i,
    output logic [DW*WPL-1:0] line_o,
    output logic [DW-1:0]     word_o
);

    logic [DW-1:0] words_q [WPL];

    // Contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < WPL; k++) begin
            if (line_we_i) begin
                words_q[k] <= line_data_i[k*DW +: DW];
            end else if (word_we_i) begin
                if (PW'(k) == word_idx_i) begin
                    words_q[k] <= word_data_i;
                end else if (zero_above_i && (PW'(k) > word_idx_i)) begin
                    words_q[k] <= '0;
                end
            end
        end
    end

    for (genvar k = 0; k < WPL; k++) begin : g_line
        assign line_o[k*DW +: DW] = words_q[k];
    end

    assign word_o = words_q[rd_idx_i];

endmodule

// File: rtl/axis_bram_line_bridge.sv
// AXI-Stream <-> wide-BRAM line bridge with a burst engine. WRITE packs WPL
// stream words per BRAM line; READ fetches lines and unpacks them to the stream.
// Optional macro AXBB_TLAST_FLUSH_EN: s_axis_tlast ends a WRITE burst early,
// zero-filling the remainder of the partial line before committing it.
module axis_bram_line_bridge
    import axis_bram_line_bridge_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter int unsigned WPL         = 36,
    parameter int unsigned AW          = 12,
    parameter int unsigned BRAM_RD_LAT = 1
) (
    input  logic              axis_aclk_i,
    input  logic              axis_aresetn_i,
    input  logic              cfg_start_i,
    input  logic              cfg_mode_i,
    input  logic [AW-1:0]     cfg_addr_i,
    input  logic [AW:0]       cfg_lines_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic [DW-1:0]     s_axis_tdata_i,
    input  logic              s_axis_tvalid_i,
    output logic              s_axis_tready_o,
    input  logic              s_axis_tlast_i,
    output logic [DW-1:0]     m_axis_tdata_o,
    output logic              m_axis_tvalid_o,
    input  logic              m_axis_tready_i,
    output logic              m_axis_tlast_o,
    output logic              bram_en_o,
    output logic              bram_we_o,
    output logic [AW-1:0]     bram_addr_o,
    output logic [DW*WPL-1:0] bram_din_o,
    input  logic [DW*WPL-1:0] bram_dout_i
);

    localparam int unsigned   LW      = DW * WPL;
    localparam int unsigned   PW      = ptr_width(WPL);
    localparam logic [PW-1:0] LastPtr = PW'(WPL - 1);
    localparam logic [1:0]    LatLast = 2'(BRAM_RD_LAT - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cur_q, cur_d;
    logic [AW:0]   rem_q, rem_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [1:0]    lat_q, lat_d;
    logic          flush_q, flush_d;

    logic          buf_word_we, buf_zero_above, buf_line_we;
    logic [LW-1:0] buf_line;
    logic [DW-1:0] buf_word;
    logic          last_line;
    logic          flush_beat;

`ifdef AXBB_TLAST_FLUSH_EN
    assign flush_beat = s_axis_tlast_i;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast_i;
    assign flush_beat   = 1'b0;
`endif

    assign last_line = (rem_q == (AW+1)'(1));

    axis_bram_line_buf #(
        .DW  (DW),
        .WPL (WPL),
        .PW  (PW)
    ) u_buf (
        .clk_i        (axis_aclk_i),
        .word_we_i    (buf_word_we),
        .word_idx_i   (ptr_q),
        .word_data_i  (s_axis_tdata_i),
        .zero_above_i (buf_zero_above),
        .line_we_i    (buf_line_we),
        .line_data_i  (bram_dout_i),
        .rd_idx_i     (ptr_q),
        .line_o       (buf_line),
        .word_o       (buf_word)
    );

    // State and burst counters.
    always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
        if (!axis_aresetn_i) begin
            state_q <= StIdle;
            cur_q   <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
            lat_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            lat_q   <= lat_d;
            flush_q <= flush_d;
        end
    end

    // Next-state logic and Moore-style interface strobes.
    always_comb begin
        state_d         = state_q;
        cur_d           = cur_q;
        rem_d           = rem_q;
        ptr_d           = ptr_q;
        lat_d           = lat_q;
        flush_d         = flush_q;
        buf_word_we     = 1'b0;
        buf_zero_above  = 1'b0;
        buf_line_we     = 1'b0;
        busy_o          = (state_q != StIdle);
        done_o          = 1'b0;
        s_axis_tready_o = 1'b0;
        m_axis_tvalid_o = 1'b0;
        m_axis_tlast_o  = 1'b0;
        bram_en_o       = 1'b0;
        bram_we_o       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cfg_start_i) begin
                    cur_d   = cfg_addr_i;
                    rem_d   = cfg_lines_i;
                    ptr_d   = '0;
                    flush_d = 1'b0;
                    if (cfg_lines_i == '0) begin
                        state_d = StFinish;
                    end else if (cfg_mode_i == MODE_READ) begin
                        state_d = StRdIssue;
                    end else begin
                        state_d = StWrFill;
                    end
                end
            end
            StWrFill: begin
                s_axis_tready_o = 1'b1;
                if (s_axis_tvalid_i) begin
                    buf_word_we = 1'b1;
                    if ((ptr_q == LastPtr) || flush_beat) begin
                        ptr_d          = '0;
                        flush_d        = flush_beat;
                        buf_zero_above = flush_beat;
                        state_d        = StWrCommit;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            StWrCommit: begin
                bram_en_o = 1'b1;
                bram_we_o = 1'b1;
                cur_d     = cur_q + 1'b1;
                rem_d     = rem_q - 1'b1;
                state_d   = (last_line || flush_q) ? StFinish : StWrFill;
            end
            StRdIssue: begin
                bram_en_o = 1'b1;
                lat_d     = '0;
                state_d   = StRdWait;
            end
            StRdWait: begin
                if (lat_q == LatLast) begin
                    buf_line_we = 1'b1;
                    ptr_d       = '0;
                    state_d     = StRdDrain;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            StRdDrain: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tlast_o  = (ptr_q == LastPtr) && last_line;
                if (m_axis_tready_i) begin
                    if (ptr_q == LastPtr) begin
                        ptr_d   = '0;
                        cur_d   = cur_q + 1'b1;
                        rem_d   = rem_q - 1'b1;
                        state_d = last_line ? StFinish : StRdIssue;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            StFinish: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Data outputs stay zero unless their strobe is active, so reset leaves them zero.
    assign bram_addr_o    = cur_q;
    assign bram_din_o     = (state_q == StWrCommit) ? buf_line : '0;
    assign m_axis_tdata_o = m_axis_tvalid_o ? buf_word : '0;

endmodule

// File: tb/tb_axis_bram_line_bridge.sv
// Self-checking bench for axis_bram_line_bridge: one instance with read latency 1
// and one with read latency 3, each backed by a behavioural BRAM.
module tb_axis_bram_line_bridge;

    localparam int unsigned DW  = 32;
    localparam int unsigned WPL = 4;
    localparam int unsigned AW  = 8;
    localparam int unsigned LW  = DW * WPL;
    localparam int unsigned NL  = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start1 = 1'b0, start3 = 1'b0, cfg_mode = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [AW:0]   cfg_lines = '0;
    logic          s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
    logic [DW-1:0] s_data = '0;

    logic          busy1, done1, s_ready1, m_valid1, m_last1, en1, we1;
    logic [DW-1:0] m_data1;
    logic [AW-1:0] addr1;
    logic [LW-1:0] din1, dout1;
    logic          busy3, done3, s_ready3, m_valid3, m_last3, en3, we3;
    logic [DW-1:0] m_data3;
    logic [AW-1:0] addr3;
    logic [LW-1:0] din3, dout3;

    axis_bram_line_bridge #(.DW(DW), .WPL(WPL), .AW(AW), .BRAM_RD_LAT(1)) dut1 (
        .axis_aclk_i(clk), .axis_aresetn_i(rst_n), .cfg_start_i(start1), .cfg_mode_i(cfg_mode),
        .cfg_addr_i(cfg_addr), .cfg_lines_i(cfg_lines), .busy_o(busy1), .done_o(done1),
        .s_axis_tdata_i(s_data), .s_axis_tvalid_i(s_valid), .s_axis_tready_o(s_ready1),
        .s_axis_tlast_i(s_last), .m_axis_tdata_o(m_data1), .m_axis_tvalid_o(m_valid1),
        .m_axis_tready_i(m_ready), .m_axis_tlast_o(m_last1), .bram_en_o(en1), .bram_we_o(we1),
        .bram_addr_o(addr1), .bram_din_o(din1), .bram_dout_i(dout1)
    );

    axis_bram_line_bridge #(.DW(DW), .WPL(WPL), .AW(AW), .BRAM_RD_LAT(3)) dut3 (
        .axis_aclk_i(clk), .axis_aresetn_i(rst_n), .cfg_start_i(start3), .cfg_mode_i(cfg_mode),
        .cfg_addr_i(cfg_addr), .cfg_lines_i(cfg_lines), .busy_o(busy3), .done_o(done3),
        .s_axis_tdata_i(s_data), .s_axis_tvalid_i(s_valid), .s_axis_tready_o(s_ready3),
        .s_axis_tlast_i(s_last), .m_axis_tdata_o(m_data3), .m_axis_tvalid_o(m_valid3),
        .m_axis_tready_i(m_ready), .m_axis_tlast_o(m_last3), .bram_en_o(en3), .bram_we_o(we3),
        .bram_addr_o(addr3), .bram_din_o(din3), .bram_dout_i(dout3)
    );

    // Behavioural BRAMs; the bench preloads through pl*_en.
    logic          pl1_en = 1'b0, pl3_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [LW-1:0] pl_data = '0;
    logic [LW-1:0] mem1 [NL];
    logic [LW-1:0] mem3 [NL];
    logic [LW-1:0] pipe3 [3];

    always @(posedge clk) begin
        if (pl1_en) mem1[pl_addr] <= pl_data;
        else if (en1 && we1) mem1[addr1] <= din1;
        if (en1 && !we1) dout1 <= mem1[addr1];
        if (pl3_en) mem3[pl_addr] <= pl_data;
        else if (en3 && we3) mem3[addr3] <= din3;
        if (en3 && !we3) pipe3[0] <= mem3[addr3];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign dout3 = pipe3[2];

    // Monitors sample mid-cycle, i.e. the values the next rising edge will see.
    int            cyc = 0;
    int            n_cmp = 0, n_err = 0;
    int            done_cnt, busy_cnt, en_cnt, rdy_cnt, stall_err, done3_cnt, beat3_n;
    logic [AW-1:0] wr_addr_q[$];
    logic [LW-1:0] wr_line_q[$];
    logic [DW-1:0] beat_q[$], beat3_q[$];
    logic          last_q[$], last3_q[$];
    int            en3_cyc[$], first3_cyc[$];
    logic          stall_p;
    logic [DW-1:0] stall_d;
    logic          stall_l;
    logic [DW-1:0] tx_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (en1 && we1) begin wr_addr_q.push_back(addr1); wr_line_q.push_back(din1); end
        if (en1) en_cnt++;
        if (done1) done_cnt++;
        if (busy1) busy_cnt++;
        if (s_ready1) rdy_cnt++;
        if (m_valid1 && m_ready) begin beat_q.push_back(m_data1); last_q.push_back(m_last1); end
        if (stall_p && (m_valid1 !== 1'b1 || m_data1 !== stall_d || m_last1 !== stall_l))
            stall_err++;
        stall_p = m_valid1 && !m_ready;
        stall_d = m_data1;
        stall_l = m_last1;
        if (en3 && !we3) en3_cyc.push_back(cyc);
        if (done3) done3_cnt++;
        if (m_valid3 && m_ready) begin
            if (beat3_n % WPL == 0) first3_cyc.push_back(cyc);
            beat3_n++;
            beat3_q.push_back(m_data3);
            last3_q.push_back(m_last3);
        end
    end

    // Reference packing: word k of a line sits at bits [k*DW +: DW].
    function automatic logic [LW-1:0] pack_tx(input int base, input int cnt);
        logic [LW-1:0] l = '0;
        for (int k = 0; k < cnt; k++) l[k*DW +: DW] = tx_q[base + k];
        return l;
    endfunction

    task automatic clear_mon();
        wr_addr_q.delete(); wr_line_q.delete(); beat_q.delete(); last_q.delete();
        beat3_q.delete(); last3_q.delete(); en3_cyc.delete(); first3_cyc.delete();
        done_cnt = 0; busy_cnt = 0; en_cnt = 0; rdy_cnt = 0; stall_err = 0;
        done3_cnt = 0; beat3_n = 0; stall_p = 1'b0;
    endtask

    task automatic preload(input bit which3, input logic [AW-1:0] a, input logic [LW-1:0] d);
        pl_addr = a; pl_data = d;
        if (which3) pl3_en = 1'b1; else pl1_en = 1'b1;
        @(posedge clk); #1;
        pl1_en = 1'b0; pl3_en = 1'b0;
    endtask

    task automatic start_burst(input bit which3, input logic mode, input logic [AW-1:0] a,
                               input logic [AW:0] n);
        cfg_mode = mode; cfg_addr = a; cfg_lines = n;
        if (which3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start3 = 1'b0;
    endtask

    task automatic drive_words(input int last_at, input bit gaps, output bit ok);
        bit acc;
        int budget;
        ok = 1'b1;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin s_valid = 1'b0; @(posedge clk); #1; end
            s_valid = 1'b1; s_data = tx_q[i]; s_last = (i == last_at);
            budget = 0;
            do begin
                @(negedge clk); acc = s_ready1;
                @(posedge clk); #1; budget++;
            end while (!acc && budget < 40);
            if (!acc) ok = 1'b0;
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_done(input bit which3, input bit rnd, input int budget, output bit ok);
        int n = 0;
        while (((which3 ? done3_cnt : done_cnt) == 0) && n < budget) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1; n++;
        end
        m_ready = 1'b1;
        ok = ((which3 ? done3_cnt : done_cnt) != 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; #1;
        n_cmp++;
        if ({busy1, done1, s_ready1, m_valid1, m_last1, en1, we1} !== 7'b0) begin
            n_err++; $display("FAIL reset_ctl1: got %b want 0", {busy1, done1, s_ready1, m_valid1, m_last1, en1, we1});
        end
        n_cmp++;
        if ({addr1, din1} !== '0) begin n_err++; $display("FAIL reset_bus1: got %0h want 0", {addr1, din1}); end
        n_cmp++;
        if ({busy3, done3, s_ready3, m_valid3, en3, we3, addr3, din3} !== '0) begin
            n_err++; $display("FAIL reset_dut3: got %0h want 0", {busy3, done3, s_ready3, m_valid3, en3, we3, addr3});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_basic();
        bit ok, ok2;
        logic [LW-1:0] exp0 = 128'h00000003_00000002_00000001_00000000;
        clear_mon();
        tx_q.delete();
        for (int i = 0; i < 8; i++) tx_q.push_back(DW'(i));
        start_burst(1'b0, 1'b0, 8'h10, 9'd2);
        drive_words(-1, 1'b0, ok);
        wait_done(1'b0, 1'b0, 50, ok2);
        n_cmp++;
        if (!(ok && ok2)) begin n_err++; $display("FAIL wr_timeout: got %b%b want 11", ok, ok2); end
        n_cmp++;
        if (wr_addr_q.size() != 2) begin n_err++; $display("FAIL wr_count: got %0d want 2", wr_addr_q.size()); end
        else begin
            n_cmp++;
            if (wr_addr_q[0] !== 8'h10 || wr_line_q[0] !== exp0) begin
                n_err++; $display("FAIL wr_line0: got %0h@%0h want %0h@10", wr_line_q[0], wr_addr_q[0], exp0);
            end
            n_cmp++;
            if (wr_addr_q[1] !== 8'h11 || wr_line_q[1] !== pack_tx(4, 4)) begin
                n_err++; $display("FAIL wr_line1: got %0h@%0h want %0h@11", wr_line_q[1], wr_addr_q[1], pack_tx(4, 4));
            end
        end
        n_cmp++;
        if (rdy_cnt != 8) begin n_err++; $display("FAIL wr_tready_cycles: got %0d want 8", rdy_cnt); end
        n_cmp++;
        if (busy_cnt != 11) begin n_err++; $display("FAIL wr_busy_cycles: got %0d want 11", busy_cnt); end
        n_cmp++;
        if (done_cnt != 1) begin n_err++; $display("FAIL wr_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_read_basic();
        bit ok;
        tx_q.delete();
        for (int i = 0; i < 8; i++) tx_q.push_back(DW'(i));
        preload(1'b0, 8'h10, pack_tx(0, 4));
        preload(1'b0, 8'h11, pack_tx(4, 4));
        for (int pass = 0; pass < 2; pass++) begin
            clear_mon();
            start_burst(1'b0, 1'b1, 8'h10, 9'd2);
            wait_done(1'b0, pass == 1, 300, ok);
            n_cmp++;
            if (!ok || beat_q.size() != 8) begin
                n_err++; $display("FAIL rd_beats(pass %0d): got %0d want 8", pass, beat_q.size());
            end
            for (int i = 0; i < beat_q.size(); i++) begin
                n_cmp++;
                if (beat_q[i] !== DW'(i) || last_q[i] !== (i == 7)) begin
                    n_err++; $display("FAIL rd_beat[%0d]: got %0h/%b want %0h/%b", i, beat_q[i], last_q[i], i, i == 7);
                end
            end
            n_cmp++;
            if (stall_err != 0 || wr_addr_q.size() != 0 || en_cnt != 2) begin
                n_err++; $display("FAIL rd_side(pass %0d): got stall=%0d wr=%0d en=%0d want 0/0/2",
                                  pass, stall_err, wr_addr_q.size(), en_cnt);
            end
            if (pass == 0) begin
                n_cmp++;
                if (busy_cnt != 13) begin n_err++; $display("FAIL rd_busy_cycles: got %0d want 13", busy_cnt); end
            end
        end
    endtask

    task automatic test_wrap_and_empty();
        bit ok, ok2;
        clear_mon();
        tx_q.delete();
        for (int i = 0; i < 8; i++) tx_q.push_back($urandom);
        start_burst(1'b0, 1'b0, 8'hFF, 9'd2);
        drive_words(-1, 1'b1, ok);
        wait_done(1'b0, 1'b0, 60, ok2);
        n_cmp++;
        if (!(ok && ok2) || wr_addr_q.size() != 2) begin
            n_err++; $display("FAIL wrap_count: got %0d want 2", wr_addr_q.size());
        end else begin
            n_cmp++;
            if (wr_addr_q[0] !== 8'hFF || wr_addr_q[1] !== 8'h00) begin
                n_err++; $display("FAIL wrap_addr: got %0h,%0h want ff,0", wr_addr_q[0], wr_addr_q[1]);
            end
            n_cmp++;
            if (wr_line_q[0] !== pack_tx(0, 4) || wr_line_q[1] !== pack_tx(4, 4)) begin
                n_err++; $display("FAIL wrap_data: got %0h want %0h", wr_line_q[1], pack_tx(4, 4));
            end
        end
        clear_mon();
        start_burst(1'b0, 1'b0, 8'h20, 9'd0);
        wait_done(1'b0, 1'b0, 4, ok);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (!ok || en_cnt != 0 || done_cnt != 1 || busy_cnt != 1) begin
            n_err++; $display("FAIL zero_lines: got en=%0d done=%0d busy=%0d want 0/1/1", en_cnt, done_cnt, busy_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        bit ok = 1'b0;
        logic [LW-1:0] l0 = {$urandom, $urandom, $urandom, $urandom};
        logic [LW-1:0] l1 = {$urandom, $urandom, $urandom, $urandom};
        preload(1'b0, 8'h30, l0);
        preload(1'b0, 8'h31, l1);
        clear_mon();
        start_burst(1'b0, 1'b1, 8'h30, 9'd2);
        repeat (4) @(posedge clk);
        #1;
        start_burst(1'b0, 1'b0, 8'h50, 9'd1);
        for (int n = 0; n < 60 && !ok; n++) begin
            if (done1) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        // Start in the done cycle must be ignored too.
        start_burst(1'b0, 1'b0, 8'h50, 9'd1);
        @(posedge clk); #1;
        n_cmp++;
        if (!ok || busy1 !== 1'b0) begin n_err++; $display("FAIL ignore_start: got ok=%b busy=%b want 1/0", ok, busy1); end
        n_cmp++;
        if (beat_q.size() != 8 || wr_addr_q.size() != 0 || done_cnt != 1) begin
            n_err++; $display("FAIL busy_burst: got beats=%0d wr=%0d done=%0d want 8/0/1",
                              beat_q.size(), wr_addr_q.size(), done_cnt);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (beat_q[i] !== (i < 4 ? l0[i*DW +: DW] : l1[(i-4)*DW +: DW])) begin
                    n_err++; $display("FAIL busy_beat[%0d]: got %0h", i, beat_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        clear_mon();
        tx_q.delete();
        for (int i = 0; i < 3; i++) tx_q.push_back($urandom);
        start_burst(1'b0, 1'b0, 8'h40, 9'd2);
        drive_words(-1, 1'b0, ok);
        rst_n = 1'b0; #1;
        n_cmp++;
        if ({busy1, done1, s_ready1, m_valid1, m_last1, en1, we1, addr1, din1} !== '0) begin
            n_err++; $display("FAIL abort_outputs: got busy=%b rdy=%b addr=%0h want 0", busy1, s_ready1, addr1);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (!ok || done_cnt != 0 || wr_addr_q.size() != 0 || busy1 !== 1'b0) begin
            n_err++; $display("FAIL abort_no_done: got done=%0d wr=%0d busy=%b want 0/0/0",
                              done_cnt, wr_addr_q.size(), busy1);
        end
    endtask

    task automatic test_rd_latency();
        bit ok;
        logic [LW-1:0] lines [3];
        for (int l = 0; l < 3; l++) begin
            lines[l] = {$urandom, $urandom, $urandom, $urandom};
            preload(1'b1, AW'(8'h20 + l), lines[l]);
        end
        clear_mon();
        start_burst(1'b1, 1'b1, 8'h20, 9'd3);
        wait_done(1'b1, 1'b0, 100, ok);
        n_cmp++;
        if (!ok || beat3_q.size() != 12 || en3_cyc.size() != 3 || first3_cyc.size() != 3) begin
            n_err++; $display("FAIL lat3_counts: got beats=%0d en=%0d want 12/3", beat3_q.size(), en3_cyc.size());
        end else begin
            for (int l = 0; l < 3; l++) begin
                n_cmp++;
                if (first3_cyc[l] - en3_cyc[l] != 4) begin
                    n_err++; $display("FAIL lat3_gap[%0d]: got %0d want 4", l, first3_cyc[l] - en3_cyc[l]);
                end
            end
            for (int i = 0; i < 12; i++) begin
                n_cmp++;
                if (beat3_q[i] !== lines[i/4][(i%4)*DW +: DW] || last3_q[i] !== (i == 11)) begin
                    n_err++; $display("FAIL lat3_beat[%0d]: got %0h/%b want %0h/%b", i, beat3_q[i],
                                      last3_q[i], lines[i/4][(i%4)*DW +: DW], i == 11);
                end
            end
        end
    endtask

    task automatic test_tlast();
        bit ok, ok2;
        clear_mon();
        tx_q.delete();
`ifdef AXBB_TLAST_FLUSH_EN
        for (int i = 0; i < 6; i++) tx_q.push_back($urandom);
        start_burst(1'b0, 1'b0, 8'h60, 9'd4);
        drive_words(5, 1'b0, ok);
        wait_done(1'b0, 1'b0, 40, ok2);
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (!(ok && ok2) || wr_addr_q.size() != 2 || done_cnt != 1) begin
            n_err++; $display("FAIL flush_count: got wr=%0d done=%0d want 2/1", wr_addr_q.size(), done_cnt);
        end else begin
            n_cmp++;
            if (wr_line_q[0] !== pack_tx(0, 4) || wr_line_q[1] !== pack_tx(4, 2) || wr_addr_q[1] !== 8'h61) begin
                n_err++; $display("FAIL flush_data: got %0h@%0h want %0h@61", wr_line_q[1], wr_addr_q[1], pack_tx(4, 2));
            end
        end
`else
        for (int i = 0; i < 4; i++) tx_q.push_back($urandom);
        start_burst(1'b0, 1'b0, 8'h60, 9'd1);
        drive_words(1, 1'b0, ok);
        wait_done(1'b0, 1'b0, 40, ok2);
        n_cmp++;
        if (!(ok && ok2) || wr_addr_q.size() != 1 || done_cnt != 1) begin
            n_err++; $display("FAIL tlast_ignored_count: got wr=%0d done=%0d want 1/1", wr_addr_q.size(), done_cnt);
        end else begin
            n_cmp++;
            if (wr_line_q[0] !== pack_tx(0, 4)) begin
                n_err++; $display("FAIL tlast_ignored_data: got %0h want %0h", wr_line_q[0], pack_tx(0, 4));
            end
        end
`endif
    endtask

    task automatic test_round_trip();
        bit ok, ok2;
        logic [AW-1:0] a;
        int n;
        for (int it = 0; it < 3; it++) begin
            a = AW'($urandom_range(0, NL - 1));
            n = $urandom_range(1, 3);
            tx_q.delete();
            for (int i = 0; i < n * WPL; i++) tx_q.push_back($urandom);
            clear_mon();
            start_burst(1'b0, 1'b0, a, (AW+1)'(n));
            drive_words(-1, 1'b1, ok);
            wait_done(1'b0, 1'b0, 100, ok2);
            n_cmp++;
            if (!(ok && ok2) || wr_addr_q.size() != n) begin
                n_err++; $display("FAIL rt_wr_count[%0d]: got %0d want %0d", it, wr_addr_q.size(), n);
            end else begin
                for (int l = 0; l < n; l++) begin
                    n_cmp++;
                    if (wr_addr_q[l] !== AW'(a + l) || wr_line_q[l] !== pack_tx(l * WPL, WPL)) begin
                        n_err++; $display("FAIL rt_wr[%0d.%0d]: got %0h@%0h want %0h@%0h", it, l,
                                          wr_line_q[l], wr_addr_q[l], pack_tx(l * WPL, WPL), AW'(a + l));
                    end
                end
            end
            clear_mon();
            start_burst(1'b0, 1'b1, a, (AW+1)'(n));
            wait_done(1'b0, 1'b1, 400, ok);
            n_cmp++;
            if (!ok || beat_q.size() != n * WPL || stall_err != 0) begin
                n_err++; $display("FAIL rt_rd[%0d]: got beats=%0d stall=%0d want %0d/0", it, beat_q.size(), stall_err, n * WPL);
            end else begin
                for (int i = 0; i < n * WPL; i++) begin
                    n_cmp++;
                    if (beat_q[i] !== tx_q[i] || last_q[i] !== (i == n * WPL - 1)) begin
                        n_err++; $display("FAIL rt_beat[%0d.%0d]: got %0h/%b want %0h", it, i, beat_q[i], last_q[i], tx_q[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_write_basic();
        test_read_basic();
        test_wrap_and_empty();
        test_start_while_busy();
        test_reset_mid_write();
        test_rd_latency();
        test_tlast();
        test_round_trip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
